// File: rtl/slice_seq_if.sv
// Bundle of the sequencer's upstream pixel, coefficient ROM, slice-engine and
// result signals. The master side is the sequencer; the slave side is the
// surrounding system (pixel source, ROM, slice engine, result sink).
interface slice_seq_if #(
  parameter int BLOCKSIZE = 32,
  parameter int WPI       = 32,
  parameter int WINROWS   = 16
);
  localparam int AW = (BLOCKSIZE * WINROWS > 1) ? $clog2(BLOCKSIZE * WINROWS) : 1;
  localparam int WW = (WPI > 1) ? $clog2(WPI) : 1;

  logic                start;
  logic                in_dv;
  logic [7:0]          in_data;
  logic                in_rdy;
  logic [AW-1:0]       coef_addr;
  logic signed [8:0]   coef_data;
  logic                sl_dvi;
  logic [7:0]          sl_data;
  logic signed [8:0]   sl_svcoeff;
  logic                sl_download;
  logic [1:0]          sl_state;
  logic                sl_done;
  logic                sl_dvo;
  logic [31:0]         sl_regout;
  logic                out_dv;
  logic [31:0]         out_data;
  logic [WW-1:0]       out_win;
  logic                band_done;
  logic                err;

  modport master (
    input  start, in_dv, in_data, coef_data, sl_state, sl_done, sl_dvo, sl_regout,
    output in_rdy, coef_addr, sl_dvi, sl_data, sl_svcoeff, sl_download,
           out_dv, out_data, out_win, band_done, err
  );

  modport slave (
    output start, in_dv, in_data, coef_data, sl_state, sl_done, sl_dvo, sl_regout,
    input  in_rdy, coef_addr, sl_dvi, sl_data, sl_svcoeff, sl_download,
           out_dv, out_data, out_win, band_done, err
  );
endinterface

// File: rtl/slice_seq.sv
// Band sequencer: streams one band of pixels (WINROWS rows of WPI windows of
// BLOCKSIZE pixels) into the slice engine with matching coefficients, waits
// for the final row download, then forwards the WPI per-window results.
module slice_seq #(
  parameter int BLOCKSIZE = 32,
  parameter int WPI       = 32,
  parameter int WINROWS   = 16
) (
  input logic          clk,
  input logic          reset,
  slice_seq_if.master  bus
);
  localparam int DATA_W = 8;
  localparam int COEF_W = 9;
  localparam int CW = (BLOCKSIZE > 1) ? $clog2(BLOCKSIZE) : 1;
  localparam int WW = (WPI > 1) ? $clog2(WPI) : 1;
  localparam int RW = (WINROWS > 1) ? $clog2(WINROWS) : 1;
  localparam int AW = (BLOCKSIZE * WINROWS > 1) ? $clog2(BLOCKSIZE * WINROWS) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, WAIT_DL, DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [WW-1:0]             win_q, win_d;
  logic [RW-1:0]             prow_q, prow_d;
  logic [RW-1:0]             drow_q, drow_d;
  logic [WW-1:0]             rd_q, rd_d;
  logic                      sl_dvi_q, sl_dvi_d;
  logic [DATA_W-1:0]         sl_data_q, sl_data_d;
  logic signed [COEF_W-1:0]  sl_svcoeff_q, sl_svcoeff_d;
  logic                      out_dv_q, out_dv_d;
  logic [31:0]               out_data_q, out_data_d;
  logic [WW-1:0]             out_win_q, out_win_d;
  logic                      band_done_q, band_done_d;
  logic                      err_q, err_d;

  logic                      in_rdy;
  logic                      accept;
  logic                      download;
  logic                      last_pix;
  logic [AW-1:0]             coef_addr;

  // Handshake, coefficient address, next-state and datapath update
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    win_d        = win_q;
    prow_d       = prow_q;
    drow_d       = drow_q;
    rd_d         = rd_q;
    sl_dvi_d     = 1'b0;
    sl_data_d    = sl_data_q;
    sl_svcoeff_d = sl_svcoeff_q;
    out_dv_d     = 1'b0;
    out_data_d   = out_data_q;
    out_win_d    = out_win_q;
    band_done_d  = 1'b0;
    err_d        = err_q;

    in_rdy    = (state_q == ACCUM) && (bus.sl_state == 2'd0);
    accept    = bus.in_dv && in_rdy;
    coef_addr = AW'(int'(prow_q) * BLOCKSIZE + int'(col_q));
    last_pix  = (col_q == CW'(BLOCKSIZE - 1)) && (win_q == WW'(WPI - 1)) &&
                (prow_q == RW'(WINROWS - 1));
    download  = bus.sl_done && (drow_q == RW'(WINROWS - 1)) &&
                ((state_q == ACCUM) || (state_q == WAIT_DL));

    // Pixel acceptance: register pixel/coefficient and advance the raster
    if (accept) begin
      sl_dvi_d     = 1'b1;
      sl_data_d    = bus.in_data;
      sl_svcoeff_d = bus.coef_data;
      if (col_q == CW'(BLOCKSIZE - 1)) begin
        col_d = '0;
        if (win_q == WW'(WPI - 1)) begin
          win_d  = '0;
          prow_d = (prow_q == RW'(WINROWS - 1)) ? '0 : prow_q + RW'(1);
        end else begin
          win_d = win_q + WW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    // Row-done tracking; the last row's done triggers the download
    if (bus.sl_done && ((state_q == ACCUM) || (state_q == WAIT_DL))) begin
      drow_d = download ? '0 : drow_q + RW'(1);
    end

    // Protocol violations from the slice engine are latched, not acted on
    if ((bus.sl_dvo && (state_q != DRAIN)) ||
        (bus.sl_done && ((state_q == IDLE) || (state_q == DRAIN)))) begin
      err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCUM;
          col_d   = '0;
          win_d   = '0;
          prow_d  = '0;
          drow_d  = '0;
          rd_d    = '0;
        end
      end
      ACCUM: begin
        if (accept && last_pix) state_d = WAIT_DL;
      end
      WAIT_DL: begin
        if (download) begin
          state_d = DRAIN;
          rd_d    = '0;
        end
      end
      DRAIN: begin
        if (bus.sl_dvo) begin
          out_dv_d   = 1'b1;
          out_data_d = bus.sl_regout;
          out_win_d  = rd_q;
          if (rd_q == WW'(WPI - 1)) begin
            rd_d        = '0;
            band_done_d = 1'b1;
            state_d     = IDLE;
          end else begin
            rd_d = rd_q + WW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      col_q        <= '0;
      win_q        <= '0;
      prow_q       <= '0;
      drow_q       <= '0;
      rd_q         <= '0;
      sl_dvi_q     <= 1'b0;
      sl_data_q    <= '0;
      sl_svcoeff_q <= '0;
      out_dv_q     <= 1'b0;
      out_data_q   <= '0;
      out_win_q    <= '0;
      band_done_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      win_q        <= win_d;
      prow_q       <= prow_d;
      drow_q       <= drow_d;
      rd_q         <= rd_d;
      sl_dvi_q     <= sl_dvi_d;
      sl_data_q    <= sl_data_d;
      sl_svcoeff_q <= sl_svcoeff_d;
      out_dv_q     <= out_dv_d;
      out_data_q   <= out_data_d;
      out_win_q    <= out_win_d;
      band_done_q  <= band_done_d;
      err_q        <= err_d;
    end
  end

  assign bus.in_rdy      = in_rdy;
  assign bus.coef_addr   = coef_addr;
  assign bus.sl_dvi      = sl_dvi_q;
  assign bus.sl_data     = sl_data_q;
  assign bus.sl_svcoeff  = sl_svcoeff_q;
  assign bus.sl_download = download;
  assign bus.out_dv      = out_dv_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_win     = out_win_q;
  assign bus.band_done   = band_done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_slice_seq.sv
// Directed bench for slice_seq with BLOCKSIZE=4, WPI=2, WINROWS=2.
module tb_slice_seq;
  localparam int BS  = 4;
  localparam int WPI = 2;
  localparam int WR  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  slice_seq_if #(.BLOCKSIZE(BS), .WPI(WPI), .WINROWS(WR)) sif ();

  slice_seq #(.BLOCKSIZE(BS), .WPI(WPI), .WINROWS(WR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  // Coefficient ROM: value = address - 3 (gives negative and positive coefficients)
  always_comb sif.coef_data = 9'(sif.coef_addr) - 9'sd3;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected coef_addr per pixel index within a band
  int addr_tab [16] = '{0, 1, 2, 3, 0, 1, 2, 3, 4, 5, 6, 7, 4, 5, 6, 7};

  function automatic logic [8:0] rom(input int a);
    return 9'(a) - 9'd3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [7:0] d);
    sif.in_dv   = 1'b1;
    sif.in_data = d;
    #1;
    chk("in_rdy", 32'(sif.in_rdy), 1);
    chk("coef_addr", 32'(sif.coef_addr), addr_tab[idx]);
    step();
    sif.in_dv = 1'b0;
    chk("sl_dvi", 32'(sif.sl_dvi), 1);
    chk("sl_data", 32'(sif.sl_data), 32'(d));
    chk("sl_svcoeff", {23'd0, sif.sl_svcoeff}, {23'd0, rom(addr_tab[idx])});
  endtask

  task automatic slice_done(input logic exp_dl);
    sif.sl_done = 1'b1;
    #1;
    chk("sl_download", 32'(sif.sl_download), 32'(exp_dl));
    step();
    sif.sl_done = 1'b0;
  endtask

  task automatic dvo(input logic [31:0] v, input int exp_win, input logic exp_bd);
    sif.sl_dvo    = 1'b1;
    sif.sl_regout = v;
    step();
    sif.sl_dvo = 1'b0;
    chk("out_dv", 32'(sif.out_dv), 1);
    chk("out_data", sif.out_data, v);
    chk("out_win", 32'(sif.out_win), exp_win);
    chk("band_done", 32'(sif.band_done), 32'(exp_bd));
  endtask

  task automatic pulse_start();
    sif.start = 1'b1;
    step();
    sif.start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_in_rdy"}, 32'(sif.in_rdy), 0);
    chk({tag, "_sl_dvi"}, 32'(sif.sl_dvi), 0);
    chk({tag, "_sl_data"}, 32'(sif.sl_data), 0);
    chk({tag, "_sl_svcoeff"}, {23'd0, sif.sl_svcoeff}, 0);
    chk({tag, "_sl_download"}, 32'(sif.sl_download), 0);
    chk({tag, "_out_dv"}, 32'(sif.out_dv), 0);
    chk({tag, "_out_data"}, sif.out_data, 0);
    chk({tag, "_out_win"}, 32'(sif.out_win), 0);
    chk({tag, "_band_done"}, 32'(sif.band_done), 0);
    chk({tag, "_err"}, 32'(sif.err), 0);
    chk({tag, "_coef_addr"}, 32'(sif.coef_addr), 0);
  endtask

  initial begin
    reset         = 1'b1;
    sif.start     = 1'b0;
    sif.in_dv     = 1'b0;
    sif.in_data   = 8'd0;
    sif.sl_state  = 2'd0;
    sif.sl_done   = 1'b0;
    sif.sl_dvo    = 1'b0;
    sif.sl_regout = 32'd0;
    step();
    step();
    reset = 1'b0;
    check_all_zero("rst");

    // in_dv while idle is ignored
    sif.in_dv   = 1'b1;
    sif.in_data = 8'h55;
    #1;
    chk("idle_in_rdy", 32'(sif.in_rdy), 0);
    step();
    sif.in_dv = 1'b0;
    chk("idle_sl_dvi", 32'(sif.sl_dvi), 0);
    chk("idle_coef_addr", 32'(sif.coef_addr), 0);

    // Band 1: data=1, one done per row, a 5-cycle slice stall mid-row
    pulse_start();
    for (int i = 0; i < 8; i++) push(i, 8'd1);
    slice_done(1'b0);
    push(8, 8'd1);
    push(9, 8'd1);
    sif.sl_state = 2'd1;
    sif.in_dv    = 1'b1;
    sif.in_data  = 8'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_in_rdy", 32'(sif.in_rdy), 0);
      chk("stall_coef_addr", 32'(sif.coef_addr), 6);
      step();
      chk("stall_sl_dvi", 32'(sif.sl_dvi), 0);
    end
    sif.in_dv    = 1'b0;
    sif.sl_state = 2'd0;
    for (int i = 10; i < 16; i++) push(i, 8'd1);
    sif.in_dv = 1'b1;
    #1;
    chk("wait_in_rdy", 32'(sif.in_rdy), 0);
    sif.in_dv = 1'b0;
    slice_done(1'b1);
    chk("drain_sl_download", 32'(sif.sl_download), 0);
    dvo(32'd8, 0, 1'b0);
    step();
    chk("gap_out_dv", 32'(sif.out_dv), 0);
    dvo(32'd8, 1, 1'b1);
    step();
    chk("post_out_dv", 32'(sif.out_dv), 0);
    chk("post_band_done", 32'(sif.band_done), 0);
    sif.in_dv = 1'b1;
    #1;
    chk("post_in_rdy", 32'(sif.in_rdy), 0);
    sif.in_dv = 1'b0;
    chk("band1_err", 32'(sif.err), 0);

    // Band 2: start ignored in ACCUM, stray dvo sets sticky err, reset in DRAIN
    pulse_start();
    for (int i = 0; i < 3; i++) push(i, 8'(16 + i));
    sif.start = 1'b1;
    #1;
    chk("restart_coef_addr", 32'(sif.coef_addr), 3);
    step();
    sif.start = 1'b0;
    chk("restart_sl_dvi", 32'(sif.sl_dvi), 0);
    chk("restart_coef_addr2", 32'(sif.coef_addr), 3);
    sif.sl_dvo    = 1'b1;
    sif.sl_regout = 32'h0000_0077;
    step();
    sif.sl_dvo = 1'b0;
    chk("stray_err", 32'(sif.err), 1);
    chk("stray_out_dv", 32'(sif.out_dv), 0);
    for (int i = 3; i < 8; i++) push(i, 8'(16 + i));
    slice_done(1'b0);
    for (int i = 8; i < 16; i++) push(i, 8'(16 + i));
    slice_done(1'b1);
    dvo(32'hDEAD_BEEF, 0, 1'b0);
    chk("sticky_err", 32'(sif.err), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_all_zero("midrst");
    step();
    chk("midrst_out_dv", 32'(sif.out_dv), 0);
    chk("midrst_band_done", 32'(sif.band_done), 0);

    // Band 3: clean re-run after the mid-band reset
    pulse_start();
    for (int i = 0; i < 8; i++) push(i, 8'(200 + i));
    slice_done(1'b0);
    for (int i = 8; i < 16; i++) push(i, 8'(200 + i));
    slice_done(1'b1);
    dvo(32'h1234_5678, 0, 1'b0);
    dvo(32'hCAFE_0001, 1, 1'b1);
    step();
    chk("band3_band_done", 32'(sif.band_done), 0);
    chk("band3_err", 32'(sif.err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/slice_seq.md
SLICE_SEQ -- requirements
Module: slice_seq

Interface
REQ-001 SHALL have parameter BLOCKSIZE, default 32, meaning pixels per window segment per row.
REQ-002 SHALL have parameter WPI, default 32, meaning windows per image row.
REQ-003 SHALL have parameter WINROWS, default 16, meaning rows per window band.
REQ-004 SHALL have one clock and a synchronous active-high reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a band.
REQ-007 SHALL have ports in_dv  in  1 and in_data  in  8: upstream pixel valid and unsigned pixel.
REQ-008 SHALL have port in_rdy  out  1  pixel accepted when in_dv and in_rdy are both high.
REQ-009 SHALL have ports coef_addr  out  clog2(BLOCKSIZE*WINROWS) and coef_data  in  9 (signed, combinational ROM read).
REQ-010 SHALL have slice-side ports sl_dvi out 1, sl_data out 8, sl_svcoeff out 9, sl_download out 1.
REQ-011 SHALL have slice-side ports sl_state in 2, sl_done in 1, sl_dvo in 1, sl_regout in 32.
REQ-012 SHALL have result ports out_dv out 1, out_data out 32, out_win out clog2(WPI).
REQ-013 SHALL have status ports band_done out 1 (pulse) and err out 1 (sticky).

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, WAIT_DL, DRAIN.
REQ-015 SHALL go IDLE->ACCUM on start; start SHALL be ignored in every other state.
REQ-016 SHALL drive in_rdy = (state==ACCUM) & (sl_state==0); in_rdy SHALL be 0 in every other state.
REQ-017 SHALL register each accepted pixel: next cycle sl_dvi=1, sl_data=in_data, sl_svcoeff=coef_data; else sl_dvi=0, data/coeff held.
REQ-018 SHALL keep counters col (0..BLOCKSIZE-1), win (0..WPI-1), prow (0..WINROWS-1), all advanced only by accepted pixels.
REQ-019 SHALL wrap col on accept at BLOCKSIZE-1 and increment win; wrap win at WPI-1 and increment prow.
REQ-020 SHALL drive coef_addr = prow*BLOCKSIZE + col, combinationally.
REQ-021 SHALL go ACCUM->WAIT_DL on the accept with col=BLOCKSIZE-1, win=WPI-1, prow=WINROWS-1.
REQ-022 SHALL keep drow (0..WINROWS-1), incremented on each sl_done in ACCUM or WAIT_DL.
REQ-023 SHALL assert sl_download combinationally = sl_done & (drow==WINROWS-1) & (state==WAIT_DL or ACCUM); drow SHALL clear on that cycle.
REQ-024 SHALL go WAIT_DL->DRAIN on the sl_download cycle.
REQ-025 SHALL forward in DRAIN each sl_dvo as out_dv=1, out_data=sl_regout, out_win=rd index, one cycle later; rd index starts at 0.
REQ-026 SHALL, after the WPI-th result is registered, pulse band_done for one cycle (same cycle as last out_dv) and go IDLE.
REQ-027 SHALL set err when sl_dvo is seen outside DRAIN, or sl_done is seen in IDLE or DRAIN; err clears only on reset; such events SHALL otherwise be ignored.
REQ-028 SHALL take no action on in_dv while in_rdy=0; upstream holds the pixel.
REQ-029 SHALL, if sl_state leaves 0 mid-row, stall acceptance without losing counter state.

Reset
REQ-030 SHALL, with reset high at a clk edge, set state IDLE, all counters 0, and in_rdy, sl_dvi, sl_data, sl_svcoeff, sl_download, out_dv, out_data, out_win, band_done, err to 0.
REQ-031 SHALL treat reset mid-band identically: no out_dv or band_done until next start.

Verification
REQ-032 Params BLOCKSIZE=4,WPI=2,WINROWS=2; start; 16 pixels data=1, coef=+1; slice model gives done per row -> sl_download on 2nd done, coef_addr sequence 0,1,2,3,0,1,2,3,4..7,4..7.
REQ-033 Same config; model issues 2 dvo with regout 8, 8 -> out_win 0,1, out_data 8,8; band_done with 2nd out_dv; state IDLE.
REQ-034 sl_state=1 for 5 cycles mid-row with in_dv=1 -> in_rdy=0, no sl_dvi, col unchanged; resumes at same coef_addr.
REQ-035 sl_dvo pulse while in ACCUM -> err=1, no out_dv; err stays 1 through band until reset.
REQ-036 reset asserted during DRAIN after 1 result -> all outputs 0 next cycle; start re-runs band, first out_win=0.
REQ-037 start pulsed during ACCUM and in_dv pulsed in IDLE -> no effect on counters, in_rdy stays 0 in IDLE.
